// File: rtl/pio_cmd_pkg.sv
// Shared PIO command encoding: opcodes, status codes, word bit positions, FSM states.
// Software headers and the bench mirror these values.
package pio_cmd_pkg;

  localparam logic [3:0] OP_NOP         = 4'd0;
  localparam logic [3:0] OP_WRITE_CTRL  = 4'd1;
  localparam logic [3:0] OP_START       = 4'd2;
  localparam logic [3:0] OP_READ_STATUS = 4'd3;
  localparam logic [3:0] OP_POP         = 4'd4;
  localparam logic [3:0] OP_READ_COUNT  = 4'd5;
  localparam logic [3:0] OP_CLEAR       = 4'd6;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_BAD_OP    = 2'd1;
  localparam logic [1:0] ST_POP_EMPTY = 2'd2;
  localparam logic [1:0] ST_DROP      = 2'd3;

  localparam int CMD_TOG_BIT  = 31;
  localparam int CMD_OP_HI    = 27;
  localparam int CMD_OP_LO    = 24;
  localparam int RSP_ACK_BIT  = 31;
  localparam int RSP_BUSY_BIT = 30;
  localparam int RSP_ST_HI    = 29;
  localparam int RSP_ST_LO    = 28;
  localparam int RSP_CNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  // Command errors outrank a pending drop report.
  function automatic logic [1:0] pick_status(input logic [1:0] err, input logic drop);
    if (err != ST_OK) return err;
    if (drop) return ST_DROP;
    return ST_OK;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Result FIFO with push/pop/clear; head word visible combinationally, zero read latency.
// Pushes are ignored when full or during clear; pops are ignored when empty or during clear.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full && !clear;
  assign pop_ok   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pio_cmd_responder.sv
// Nios PIO command responder: toggle-handshake commands, ack flips 4 edges after cmd_word changes.
// Results are accepted while the FIFO has room (res_ready = !full); overflowing words are dropped and reported.
module pio_cmd_responder
  import pio_cmd_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [31:0]       cmd_word,
  input  logic [DATA_W-1:0] arg_word,
  output logic [31:0]       rsp_word,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic [DATA_W-1:0] ctrl_word,
  output logic              ctrl_start,
  input  logic [DATA_W-1:0] acc_status
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state;
  state_e            state_nxt;
  logic [31:0]       cmd_q;
  logic [DATA_W-1:0] arg_q;
  logic              last_tog;
  logic              busy_q;
  logic              ack_q;
  logic [1:0]        status_q;
  logic [1:0]        err_q;
  logic [3:0]        op_q;
  logic              drop_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] ctrl_word_q;

  logic              accept;
  logic              load_ctrl;
  logic              load_status;
  logic              load_head;
  logic              load_count;
  logic [1:0]        exec_err;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              drop_evt;
  logic              cmd_unused;

  assign cmd_unused = ^{cmd_q[30:28], cmd_q[23:0]};

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .push      (fifo_push),
    .push_data (res_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .clear     (fifo_clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res_ready = !fifo_full;
  assign fifo_push = res_valid && res_ready;
  // A word is lost either because there was no room or because CLEAR swallowed it.
  assign drop_evt  = res_valid && (fifo_full || fifo_clear);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    load_ctrl   = 1'b0;
    load_status = 1'b0;
    load_head   = 1'b0;
    load_count  = 1'b0;
    fifo_pop    = 1'b0;
    fifo_clear  = 1'b0;
    ctrl_start  = 1'b0;
    exec_err    = ST_OK;
    case (state)
      S_IDLE: begin
        if (cmd_q[CMD_TOG_BIT] != last_tog) begin
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_DONE;
        case (op_q)
          OP_NOP:         ;
          OP_WRITE_CTRL:  load_ctrl = 1'b1;
          OP_START:       ctrl_start = 1'b1;
          OP_READ_STATUS: load_status = 1'b1;
          OP_POP: begin
            if (fifo_empty) begin
              exec_err = ST_POP_EMPTY;
            end else begin
              fifo_pop  = 1'b1;
              load_head = 1'b1;
            end
          end
          OP_READ_COUNT:  load_count = 1'b1;
          OP_CLEAR:       fifo_clear = 1'b1;
          default:        exec_err = ST_BAD_OP;
        endcase
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cmd_q       <= '0;
      arg_q       <= '0;
      last_tog    <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      status_q    <= ST_OK;
      err_q       <= ST_OK;
      op_q        <= OP_NOP;
      drop_q      <= 1'b0;
      rsp_data_q  <= '0;
      ctrl_word_q <= '0;
    end else begin
      cmd_q <= cmd_word;
      arg_q <= arg_word;
      if (accept) begin
        last_tog <= cmd_q[CMD_TOG_BIT];
        busy_q   <= 1'b1;
        op_q     <= cmd_q[CMD_OP_HI:CMD_OP_LO];
      end
      if (state == S_EXEC) err_q <= exec_err;
      if (load_ctrl) ctrl_word_q <= arg_q;
      if (load_status)     rsp_data_q <= acc_status;
      else if (load_head)  rsp_data_q <= fifo_head;
      else if (load_count) rsp_data_q <= DATA_W'(fifo_count);
      if (state == S_DONE) begin
        status_q <= pick_status(err_q, drop_q);
        ack_q    <= ~ack_q;
        busy_q   <= 1'b0;
      end
      // A drop in the ack cycle itself survives to be reported on the next command.
      if (drop_evt)              drop_q <= 1'b1;
      else if (state == S_DONE)  drop_q <= 1'b0;
    end
  end

  // Busy shows as soon as a new toggle has been registered, ahead of the FSM leaving IDLE.
  assign rsp_word  = {ack_q, busy_q | accept, status_q, 12'd0, RSP_CNT_W'(fifo_count)};
  assign rsp_data  = rsp_data_q;
  assign ctrl_word = ctrl_word_q;

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Directed bench for pio_cmd_responder: inputs driven and outputs sampled on the falling edge.
module tb_pio_cmd_responder;

  logic        clk_clk;
  logic        reset_reset;
  logic [31:0] cmd_word;
  logic [31:0] arg_word;
  logic [31:0] rsp_word;
  logic [31:0] rsp_data;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic [31:0] ctrl_word;
  logic        ctrl_start;
  logic [31:0] acc_status;

  int   checks;
  int   errors;
  logic tog;
  int   busy_seen;
  int   start_seen;
  logic ack_early;

  pio_cmd_responder #(.DEPTH(16), .DATA_W(32)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .cmd_word    (cmd_word),
    .arg_word    (arg_word),
    .rsp_word    (rsp_word),
    .rsp_data    (rsp_data),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .ctrl_word   (ctrl_word),
    .ctrl_start  (ctrl_start),
    .acc_status  (acc_status)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Issues one command and waits the four edges until its ack, tracking busy/start/early ack.
  task automatic do_cmd(input logic [3:0] op, input logic [31:0] arg);
    logic ack0;
    @(negedge clk_clk);
    ack0 = rsp_word[31];
    arg_word = arg;
    tog = ~tog;
    cmd_word = {tog, 3'b000, op, 24'h0};
    busy_seen = 0;
    start_seen = 0;
    ack_early = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_clk);
      if (rsp_word[30]) busy_seen++;
      if (ctrl_start) start_seen++;
      if (i < 4 && rsp_word[31] != ack0) ack_early = 1'b1;
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk_clk);
    res_valid = 1'b1;
    res_data = d;
    @(negedge clk_clk);
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b0;
    cmd_word = '0; arg_word = '0; res_valid = 1'b0; res_data = '0;
    acc_status = 32'hA5A5_0001;
    tog = 1'b0;
    #1 reset_reset = 1'b1;
    #1;
    checks++; if (rsp_word !== 32'h0) begin errors++; $display("FAIL reset_rsp_word got %h want 0", rsp_word); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (ctrl_word !== 32'h0 || ctrl_start !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %h/%b want 0/0", ctrl_word, ctrl_start); end
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got %b want 1", res_ready); end
  endtask

  task automatic test_write_ctrl();
    do_cmd(4'd1, 32'hDEAD_BEEF);
    checks++; if (ack_early !== 1'b0) begin errors++; $display("FAIL wr_ack_early got %b want 0", ack_early); end
    checks++; if (rsp_word[31] !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", rsp_word[31]); end
    checks++; if (busy_seen != 3) begin errors++; $display("FAIL wr_busy_cycles got %0d want 3", busy_seen); end
    checks++; if (rsp_word[30] !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b want 0", rsp_word[30]); end
    checks++; if (ctrl_word !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ctrl_word got %h want deadbeef", ctrl_word); end
    checks++; if (rsp_word[29:28] !== 2'd0) begin errors++; $display("FAIL wr_status got %0d want 0", rsp_word[29:28]); end
  endtask

  task automatic test_start();
    do_cmd(4'd2, 32'h0);
    checks++; if (start_seen != 1) begin errors++; $display("FAIL start_pulse_cycles got %0d want 1", start_seen); end
    checks++; if (rsp_word[31] !== 1'b0) begin errors++; $display("FAIL start_ack got %b want 0", rsp_word[31]); end
    checks++; if (rsp_word[29:28] !== 2'd0) begin errors++; $display("FAIL start_status got %0d want 0", rsp_word[29:28]); end
    checks++; if (ctrl_word !== 32'hDEAD_BEEF) begin errors++; $display("FAIL start_ctrl_kept got %h want deadbeef", ctrl_word); end
  endtask

  task automatic test_pop();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) push_word(words[i]);
    checks++; if (rsp_word[15:0] !== 16'd3) begin errors++; $display("FAIL pop_count_before got %0d want 3", rsp_word[15:0]); end
    for (int i = 0; i < 3; i++) begin
      do_cmd(4'd4, 32'h0);
      checks++; if (rsp_data !== words[i] || rsp_word[29:28] !== 2'd0) begin
        errors++; $display("FAIL pop_%0d got data %h status %0d want %h status 0", i, rsp_data, rsp_word[29:28], words[i]);
      end
    end
    do_cmd(4'd4, 32'h0);
    checks++; if (rsp_word[29:28] !== 2'd2) begin errors++; $display("FAIL pop_empty_status got %0d want 2", rsp_word[29:28]); end
    checks++; if (rsp_data !== 32'h33) begin errors++; $display("FAIL pop_empty_data got %h want 33", rsp_data); end
    checks++; if (rsp_word[15:0] !== 16'd0 || rsp_word[31] !== tog) begin
      errors++; $display("FAIL pop_empty_count_ack got %0d/%b want 0/%b", rsp_word[15:0], rsp_word[31], tog);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk_clk);
      if (i == 15) begin
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL full_ready_at15 got %b want 1", res_ready); end
      end
      if (i == 16) begin
        checks++; if (res_ready !== 1'b0 || rsp_word[15:0] !== 16'd16) begin
          errors++; $display("FAIL full_at16 got ready %b count %0d want 0/16", res_ready, rsp_word[15:0]);
        end
      end
      res_valid = 1'b1;
      res_data = 32'h100 + i;
    end
    @(negedge clk_clk);
    res_valid = 1'b0;
    checks++; if (rsp_word[15:0] !== 16'd16) begin errors++; $display("FAIL full_count_after17 got %0d want 16", rsp_word[15:0]); end
    do_cmd(4'd5, 32'h0);
    checks++; if (rsp_word[29:28] !== 2'd3) begin errors++; $display("FAIL drop_status got %0d want 3", rsp_word[29:28]); end
    checks++; if (rsp_data !== 32'd16) begin errors++; $display("FAIL read_count got %0d want 16", rsp_data); end
    do_cmd(4'd0, 32'h0);
    checks++; if (rsp_word[29:28] !== 2'd0) begin errors++; $display("FAIL drop_cleared got %0d want 0", rsp_word[29:28]); end
    do_cmd(4'd6, 32'h0);
    checks++; if (rsp_word[15:0] !== 16'd0 || res_ready !== 1'b1) begin
      errors++; $display("FAIL clear got count %0d ready %b want 0/1", rsp_word[15:0], res_ready);
    end
  endtask

  task automatic test_push_pop_same();
    for (int i = 0; i < 5; i++) push_word(32'hA0 + i);
    checks++; if (rsp_word[15:0] !== 16'd5) begin errors++; $display("FAIL pp_count_before got %0d want 5", rsp_word[15:0]); end
    @(negedge clk_clk);
    tog = ~tog;
    cmd_word = {tog, 3'b000, 4'd4, 24'h0};
    @(negedge clk_clk);
    @(negedge clk_clk);
    res_valid = 1'b1;
    res_data = 32'hA5;
    @(negedge clk_clk);
    res_valid = 1'b0;
    checks++; if (rsp_word[15:0] !== 16'd5) begin errors++; $display("FAIL pp_count got %0d want 5", rsp_word[15:0]); end
    checks++; if (rsp_data !== 32'hA0) begin errors++; $display("FAIL pp_data got %h want a0", rsp_data); end
    @(negedge clk_clk);
    checks++; if (rsp_word[31] !== tog || rsp_word[15:0] !== 16'd5) begin
      errors++; $display("FAIL pp_ack got ack %b count %0d want %b/5", rsp_word[31], rsp_word[15:0], tog);
    end
  endtask

  task automatic test_bad_op();
    do_cmd(4'd9, 32'h1234_5678);
    checks++; if (rsp_word[29:28] !== 2'd1) begin errors++; $display("FAIL bad_status got %0d want 1", rsp_word[29:28]); end
    checks++; if (ctrl_word !== 32'hDEAD_BEEF || rsp_data !== 32'hA0) begin
      errors++; $display("FAIL bad_side_effect got ctrl %h data %h want deadbeef/a0", ctrl_word, rsp_data);
    end
    checks++; if (rsp_word[15:0] !== 16'd5 || rsp_word[31] !== tog) begin
      errors++; $display("FAIL bad_count_ack got %0d/%b want 5/%b", rsp_word[15:0], rsp_word[31], tog);
    end
  endtask

  task automatic test_reset_mid_exec();
    int pulses;
    int acks;
    @(negedge clk_clk);
    tog = ~tog;
    cmd_word = {tog, 3'b000, 4'd2, 24'h0};
    @(negedge clk_clk);
    @(negedge clk_clk);
    checks++; if (ctrl_start !== 1'b1) begin errors++; $display("FAIL rst_exec_reached got %b want 1", ctrl_start); end
    #1 reset_reset = 1'b1;
    cmd_word = '0;
    arg_word = '0;
    #1;
    checks++; if (rsp_word !== 32'h0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_rsp got %h/%h want 0/0", rsp_word, rsp_data);
    end
    checks++; if (ctrl_word !== 32'h0 || ctrl_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got %h/%b want 0/0", ctrl_word, ctrl_start);
    end
    @(negedge clk_clk);
    reset_reset = 1'b0;
    tog = 1'b0;
    pulses = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_clk);
      if (ctrl_start) pulses++;
      if (rsp_word[31]) acks++;
    end
    checks++; if (pulses != 0 || acks != 0) begin
      errors++; $display("FAIL rst_mid_after got pulses %0d acks %0d want 0/0", pulses, acks);
    end
    do_cmd(4'd0, 32'h0);
    checks++; if (rsp_word[31] !== 1'b1 || rsp_word[29:28] !== 2'd0) begin
      errors++; $display("FAIL rst_restart got ack %b status %0d want 1/0", rsp_word[31], rsp_word[29:28]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_ctrl();
    test_start();
    test_pop();
    test_full();
    test_push_pop_same();
    test_bad_op();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
